nx_fifo_ctrl_ram_1r1w_pf: RTL and testbench

NX_FIFO_CTRL_RAM_1R1W_PF -- requirements
Module: nx_fifo_ctrl_ram_1r1w_pf

---
 rtl/nx_fifo_ctrl_ram_1r1w_pf_if.sv | 49 ++++
 rtl/nx_fifo_ctrl_ram_1r1w_pf.sv | 132 +++++++++++++
 tb/tb_nx_fifo_ctrl_ram_1r1w_pf.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/nx_fifo_ctrl_ram_1r1w_pf_if.sv
// Bundle for the prefetching FIFO controller: user push/pop side, RAM port
// side and status. slave = the controller, master = its environment.
interface nx_fifo_ctrl_ram_1r1w_pf_if #(
  parameter int WIDTH = 71,
  parameter int AW    = 11,
  parameter int CW    = 12
);
  logic             clear;
  logic             wen;
  logic [WIDTH-1:0] wdata;
  logic             ren;
  logic [CW-1:0]    afull_thresh;
  logic [CW-1:0]    aempty_thresh;

  logic             mem_wen;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_ren;
  logic [AW-1:0]    mem_raddr;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ecc_error;

  logic             empty;
  logic             full;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    used_slots;
  logic [CW-1:0]    free_slots;
  logic [WIDTH-1:0] rdata;
  logic             rerr;
  logic             overflow;
  logic             underflow;

  modport slave (
    input  clear, wen, wdata, ren, afull_thresh, aempty_thresh,
    input  mem_rdata, mem_ecc_error,
    output mem_wen, mem_waddr, mem_wdata, mem_ren, mem_raddr,
    output empty, full, almost_full, almost_empty, used_slots, free_slots,
    output rdata, rerr, overflow, underflow
  );

  modport master (
    output clear, wen, wdata, ren, afull_thresh, aempty_thresh,
    output mem_rdata, mem_ecc_error,
    input  mem_wen, mem_waddr, mem_wdata, mem_ren, mem_raddr,
    input  empty, full, almost_full, almost_empty, used_slots, free_slots,
    input  rdata, rerr, overflow, underflow
  );
endinterface

// File: rtl/nx_fifo_ctrl_ram_1r1w_pf.sv
// FIFO controller over an external 1R1W RAM with a small show-ahead prefetch
// buffer that hides the RAM read latency and sustains one pop per cycle.
module nx_fifo_ctrl_ram_1r1w_pf #(
  parameter int DEPTH      = 2048,
  parameter int WIDTH      = 71,
  parameter int RD_LATENCY = 1
) (
  input logic clk,
  input logic rst_n,
  nx_fifo_ctrl_ram_1r1w_pf_if.slave bus
);
  localparam int PF    = RD_LATENCY + 1;
  localparam int TOTAL = DEPTH + PF;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int RCW   = $clog2(DEPTH + 1);
  localparam int PW    = $clog2(PF);
  localparam int PCW   = $clog2(PF + 1);
  localparam int SW    = $clog2(2 * PF + 1);

  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [RCW-1:0]   ram_cnt_q, ram_cnt_d;
  logic [PW-1:0]    pf_head_q, pf_head_d, pf_tail_q, pf_tail_d;
  logic [PCW-1:0]   pf_cnt_q, pf_cnt_d;
  logic [CW-1:0]    used_q, used_d;
  logic [RD_LATENCY:1] vld_q;
  logic             ovf_q, udf_q;
  logic [WIDTH-1:0] pf_data_q [PF];
  logic [PF-1:0]    pf_err_q;

  logic             full, empty, push, pop, rd, ret;
  logic [SW-1:0]    inflight;

  function automatic logic [AW-1:0] nxt_w(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  function automatic logic [PW-1:0] nxt_p(input logic [PW-1:0] p);
    return (p == PW'(PF - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 1; i <= RD_LATENCY; i++) inflight += SW'(vld_q[i]);
  end

  assign full  = (ram_cnt_q == RCW'(DEPTH));
  assign empty = (pf_cnt_q == '0);
  assign push  = bus.wen & ~full & ~bus.clear;
  assign pop   = bus.ren & ~empty & ~bus.clear;
  // Only issue a read when its return is guaranteed a prefetch slot.
  assign rd    = (ram_cnt_q != '0) & ~bus.clear &
                 ((SW'(pf_cnt_q) + inflight) < (SW'(PF) + SW'(pop)));
  assign ret   = vld_q[RD_LATENCY] & ~bus.clear;

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    pf_head_d = pf_head_q;
    pf_tail_d = pf_tail_q;
    ram_cnt_d = ram_cnt_q;
    pf_cnt_d  = pf_cnt_q;
    used_d    = used_q;
    if (bus.clear) begin
      wptr_d    = '0;
      rptr_d    = '0;
      pf_head_d = '0;
      pf_tail_d = '0;
      ram_cnt_d = '0;
      pf_cnt_d  = '0;
      used_d    = '0;
    end else begin
      if (push) wptr_d    = nxt_w(wptr_q);
      if (rd)   rptr_d    = nxt_w(rptr_q);
      if (ret)  pf_tail_d = nxt_p(pf_tail_q);
      if (pop)  pf_head_d = nxt_p(pf_head_q);
      ram_cnt_d = ram_cnt_q + RCW'(push) - RCW'(rd);
      pf_cnt_d  = pf_cnt_q + PCW'(ret) - PCW'(pop);
      used_d    = used_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      pf_head_q <= '0;
      pf_tail_q <= '0;
      ram_cnt_q <= '0;
      pf_cnt_q  <= '0;
      used_q    <= '0;
      vld_q     <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      pf_err_q  <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      pf_head_q <= pf_head_d;
      pf_tail_q <= pf_tail_d;
      ram_cnt_q <= ram_cnt_d;
      pf_cnt_q  <= pf_cnt_d;
      used_q    <= used_d;
      // Clearing the return pipe drops any read still in flight across a flush.
      vld_q[1]  <= rd;
      for (int i = 2; i <= RD_LATENCY; i++) vld_q[i] <= vld_q[i-1] & ~bus.clear;
      ovf_q     <= bus.wen & full & ~bus.clear;
      udf_q     <= bus.ren & empty & ~bus.clear;
      if (ret) pf_err_q[pf_tail_q] <= bus.mem_ecc_error;
    end
  end

  always_ff @(posedge clk) begin
    if (ret) pf_data_q[pf_tail_q] <= bus.mem_rdata;
  end

  assign bus.mem_wen      = push;
  assign bus.mem_waddr    = wptr_q;
  assign bus.mem_wdata    = bus.wdata;
  assign bus.mem_ren      = rd;
  assign bus.mem_raddr    = rptr_q;
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_full  = (used_q >= bus.afull_thresh);
  assign bus.almost_empty = (used_q <= bus.aempty_thresh);
  assign bus.used_slots   = used_q;
  assign bus.free_slots   = CW'(TOTAL) - used_q;
  assign bus.rdata        = pf_data_q[pf_head_q];
  assign bus.rerr         = pf_err_q[pf_head_q] & ~empty;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_nx_fifo_ctrl_ram_1r1w_pf.sv
// Directed bench: DEPTH=8, WIDTH=8, RD_LATENCY=2 with a behavioural RAM;
// a negedge monitor pops the expected-data queue on every accepted pop.
module tb_nx_fifo_ctrl_ram_1r1w_pf;
  logic clk, rst_n;
  int   total, bad, ovf_cnt, udf_cnt, rd_cnt, ecc_at;

  typedef struct { logic [7:0] d; logic e; } exp_t;
  exp_t sb[$];

  nx_fifo_ctrl_ram_1r1w_pf_if #(.WIDTH(8), .AW(3), .CW(4)) bus ();

  nx_fifo_ctrl_ram_1r1w_pf #(.DEPTH(8), .WIDTH(8), .RD_LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: write at the edge, read data appears two cycles after mem_ren.
  logic [7:0] ram [8];
  logic [7:0] s1_d, s2_d;
  logic       s1_e, s2_e;
  always @(posedge clk) begin
    if (bus.mem_wen) ram[bus.mem_waddr] <= bus.mem_wdata;
    if (bus.mem_ren) begin
      rd_cnt <= rd_cnt + 1;
      s1_d   <= ram[bus.mem_raddr];
      s1_e   <= ((rd_cnt + 1) == ecc_at);
    end
    s2_d <= s1_d;
    s2_e <= s1_e;
  end
  assign bus.mem_rdata     = s2_d;
  assign bus.mem_ecc_error = s2_e;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_add(input logic [7:0] d, input logic e);
    exp_t x;
    x.d = d;
    x.e = e;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.overflow)  ovf_cnt++;
      if (bus.underflow) udf_cnt++;
      if (bus.ren && !bus.empty && !bus.clear) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop_unexpected: got data %0d expected no pop", bus.rdata);
        end else begin
          exp_t x;
          x = sb.pop_front();
          chk("pop_data", int'(bus.rdata), int'(x.d));
          chk("pop_rerr", int'(bus.rerr), int'(x.e));
        end
      end
    end
  end

  initial begin
    int o0, u0;
    total = 0; bad = 0; ovf_cnt = 0; udf_cnt = 0; rd_cnt = 0; ecc_at = 0;
    rst_n = 1'b0;
    bus.clear = 0; bus.wen = 0; bus.ren = 0; bus.wdata = '0;
    bus.afull_thresh = 4'd0; bus.aempty_thresh = 4'd2;
    #12;
    chk("rst_empty",  int'(bus.empty), 1);
    chk("rst_full",   int'(bus.full), 0);
    chk("rst_aempty", int'(bus.almost_empty), 1);
    chk("rst_afull0", int'(bus.almost_full), 1);
    chk("rst_used",   int'(bus.used_slots), 0);
    chk("rst_free",   int'(bus.free_slots), 11);
    chk("rst_memwen", int'(bus.mem_wen), 0);
    chk("rst_memren", int'(bus.mem_ren), 0);
    chk("rst_ovf",    int'(bus.overflow), 0);
    chk("rst_udf",    int'(bus.underflow), 0);
    chk("rst_rerr",   int'(bus.rerr), 0);
    bus.afull_thresh = 4'd9;
    #1;
    chk("rst_afull9", int'(bus.almost_full), 0);
    step();
    rst_n = 1'b1;

    // Fill: 12 pushes, only 11 fit; the last one overflows.
    for (int k = 0; k < 12; k++) begin
      bus.wen = 1; bus.wdata = 8'(k);
      if (k < 11) sb_add(8'(k), 1'b0);
      @(negedge clk);
      chk("fill_used",   int'(bus.used_slots), k);
      chk("fill_full",   int'(bus.full), (k == 11) ? 1 : 0);
      chk("fill_afull",  int'(bus.almost_full), (k >= 9) ? 1 : 0);
      chk("fill_aempty", int'(bus.almost_empty), (k <= 2) ? 1 : 0);
      step();
    end
    bus.wen = 0;
    @(negedge clk);
    chk("ovf_pulse", int'(bus.overflow), 1);
    chk("full_used", int'(bus.used_slots), 11);
    chk("full_free", int'(bus.free_slots), 0);
    chk("full_flag", int'(bus.full), 1);
    step();
    @(negedge clk);
    chk("ovf_end", int'(bus.overflow), 0);
    step();

    // Streaming: pushes trail the pops by one cycle so the full RAM has a slot.
    o0 = ovf_cnt; u0 = udf_cnt;
    for (int b = 0; b < 22; b++) begin
      bus.ren = 1;
      bus.wen = (b >= 1 && b <= 11);
      bus.wdata = 8'(8'h20 + b - 1);
      if (b >= 1 && b <= 11) sb_add(8'(8'h20 + b - 1), 1'b0);
      @(negedge clk);
      chk("stream_b2b", int'(bus.empty), 0);
      step();
    end
    bus.ren = 0; bus.wen = 0;
    @(negedge clk);
    chk("stream_empty", int'(bus.empty), 1);
    chk("stream_used",  int'(bus.used_slots), 0);
    chk("stream_sb",    sb.size(), 0);
    chk("stream_ovf",   ovf_cnt - o0, 0);
    chk("stream_udf",   udf_cnt - u0, 0);
    step();

    // Single word latency: visible on the 4th cycle after the accepting edge.
    bus.wen = 1; bus.wdata = 8'h5A; sb_add(8'h5A, 1'b0);
    @(negedge clk);
    chk("wr_memwen",   int'(bus.mem_wen), 1);
    chk("wr_waddr",    int'(bus.mem_waddr), 6);
    step();
    bus.wen = 0;
    for (int j = 1; j <= 4; j++) begin
      bus.ren = (j == 4);
      @(negedge clk);
      chk("lat_empty", int'(bus.empty), (j < 4) ? 1 : 0);
      step();
    end
    bus.ren = 0;
    @(negedge clk);
    chk("single_empty", int'(bus.empty), 1);
    chk("single_used",  int'(bus.used_slots), 0);
    step();

    // ECC flag on the third read return only.
    ecc_at = rd_cnt + 3;
    for (int k = 0; k < 5; k++) begin
      bus.wen = 1; bus.wdata = 8'(8'h30 + k);
      sb_add(8'(8'h30 + k), (k == 2));
      step();
    end
    bus.wen = 0;
    repeat (6) step();
    bus.ren = 1;
    repeat (5) step();
    bus.ren = 0;
    ecc_at = 0;
    @(negedge clk);
    chk("ecc_empty", int'(bus.empty), 1);
    step();

    // Clear with two reads in flight and wen/ren asserted.
    o0 = ovf_cnt; u0 = udf_cnt;
    for (int k = 0; k < 3; k++) begin
      bus.wen = 1; bus.wdata = 8'(8'h40 + k);
      sb_add(8'(8'h40 + k), 1'b0);
      step();
    end
    bus.clear = 1; bus.wen = 1; bus.ren = 1; bus.wdata = 8'hEE;
    sb.delete();
    @(negedge clk);
    chk("clr_memwen", int'(bus.mem_wen), 0);
    chk("clr_memren", int'(bus.mem_ren), 0);
    step();
    bus.clear = 0; bus.wen = 0; bus.ren = 0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("clr_empty", int'(bus.empty), 1);
      chk("clr_used",  int'(bus.used_slots), 0);
      step();
    end
    chk("clr_ovf", ovf_cnt - o0, 0);
    chk("clr_udf", udf_cnt - u0, 0);
    bus.wen = 1; bus.wdata = 8'h77; sb_add(8'h77, 1'b0);
    @(negedge clk);
    chk("clr_waddr", int'(bus.mem_waddr), 0);
    step();
    bus.wen = 0;
    repeat (4) step();
    bus.ren = 1;
    step();
    bus.ren = 0;

    // Pop on empty.
    u0 = udf_cnt;
    bus.ren = 1;
    step();
    bus.ren = 0;
    @(negedge clk);
    chk("udf_pulse", int'(bus.underflow), 1);
    chk("udf_used",  int'(bus.used_slots), 0);
    chk("udf_empty", int'(bus.empty), 1);
    step();
    @(negedge clk);
    chk("udf_end",   int'(bus.underflow), 0);
    chk("udf_count", udf_cnt - u0, 1);
    chk("final_sb",  sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
